// File: rtl/lm_sm_pkg.sv
// Shared constants for the LM/SM multi-cycle sequencer: opcodes of the
// instructions it interacts with and the sequencer state encoding.
package lm_sm_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/lsb_priority_enc8.sv
// Lowest-set-bit encoder for an 8-bit register mask, plus a flag that is
// high when exactly one bit of the mask is set.
module lsb_priority_enc8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       single
);

    always_comb begin
        idx = 3'd0;
        // Scan from the top so the lowest set bit is the last one written.
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) begin
                idx = i[2:0];
            end
        end
    end

    assign single = (mask != 8'd0) && ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// Breaks an LM/SM instruction into one load/store micro-op per selected
// register, lowest register first, with consecutive memory addresses.
module lm_sm_sequencer
    import lm_sm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_sm,
    input  logic [7:0]  reg_list,
    input  logic [15:0] base_addr,
    input  logic        stall_in,
    input  logic        flush,
    output logic        stall_upstream,
    output logic        uop_valid,
    output logic        uop_is_sm,
    output logic [2:0]  uop_reg_add,
    output logic [15:0] uop_mem_addr,
    output logic        uop_last,
    output logic        done
);

    seq_state_e  state;
    logic [7:0]  mask;
    logic [15:0] addr;
    logic        op;
    logic        done_q;
    logic [2:0]  low_idx;
    logic        mask_single;
    logic        run;

    lsb_priority_enc8 u_enc (
        .mask   (mask),
        .idx    (low_idx),
        .single (mask_single)
    );

    assign run = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            mask   <= 8'd0;
            addr   <= 16'd0;
            op     <= 1'b0;
            done_q <= 1'b0;
        end else if (flush) begin
            // A redirect drops the instruction silently: no done pulse.
            state  <= ST_IDLE;
            mask   <= 8'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (reg_list != 8'd0) begin
                            mask  <= reg_list;
                            addr  <= base_addr;
                            op    <= is_sm;
                            state <= ST_RUN;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!stall_in) begin
                        mask <= mask & (mask - 8'd1);
                        addr <= addr + 16'd1;
                        if (mask_single) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign uop_valid    = run;
    assign uop_is_sm    = run && op;
    assign uop_reg_add  = run ? low_idx : 3'd0;
    assign uop_mem_addr = run ? addr : 16'd0;
    assign uop_last     = run && mask_single;
    assign done         = done_q;

    // Gated by reset so every output reads 0 while reset is held.
    assign stall_upstream = reset_n &&
        ((run && !(mask_single && !stall_in)) ||
         (start && (reg_list != 8'd0) && (state == ST_IDLE)));

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: directed scenarios followed by random traffic,
// all outputs compared each cycle against a queue-based transfer model.
module tb_lm_sm_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_sm = 1'b0;
    logic [7:0]  reg_list = 8'd0;
    logic [15:0] base_addr = 16'd0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic        stall_upstream;
    logic        uop_valid;
    logic        uop_is_sm;
    logic [2:0]  uop_reg_add;
    logic [15:0] uop_mem_addr;
    logic        uop_last;
    logic        done;

    lm_sm_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .is_sm          (is_sm),
        .reg_list       (reg_list),
        .base_addr      (base_addr),
        .stall_in       (stall_in),
        .flush          (flush),
        .stall_upstream (stall_upstream),
        .uop_valid      (uop_valid),
        .uop_is_sm      (uop_is_sm),
        .uop_reg_add    (uop_reg_add),
        .uop_mem_addr   (uop_mem_addr),
        .uop_last       (uop_last),
        .done           (done)
    );

    always #5 clk = ~clk;

    // Model: pending transfers as {reg[2:0], addr[15:0]}, oldest first.
    logic [18:0] exp_q[$];
    logic        exp_op = 1'b0;
    logic        exp_done = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic        busy;
        logic [18:0] head;
        logic        last;
        busy = (exp_q.size() != 0);
        head = busy ? exp_q[0] : 19'd0;
        last = (exp_q.size() == 1);
        check("uop_valid", 32'(uop_valid), 32'(busy));
        check("uop_is_sm", 32'(uop_is_sm), 32'(busy && exp_op));
        check("uop_reg_add", 32'(uop_reg_add), 32'(head[18:16]));
        check("uop_mem_addr", 32'(uop_mem_addr), 32'(head[15:0]));
        check("uop_last", 32'(uop_last), 32'(last));
        check("done", 32'(done), 32'(exp_done));
        check("stall_upstream", 32'(stall_upstream),
              32'((busy && !(last && !stall_in)) ||
                  (start && reg_list != 8'd0 && !busy)));
    endtask

    task automatic model_edge(input logic s, input logic sm, input logic [7:0] rl,
                              input logic [15:0] b, input logic st, input logic fl);
        exp_done = 1'b0;
        if (fl) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            if (!st) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) exp_done = 1'b1;
            end
        end else if (s) begin
            if (rl == 8'd0) begin
                exp_done = 1'b1;
            end else begin
                logic [15:0] a;
                a = b;
                exp_op = sm;
                for (int i = 0; i < 8; i++) begin
                    if (rl[i]) begin
                        exp_q.push_back({3'(i), a});
                        a = a + 16'd1;
                    end
                end
            end
        end
    endtask

    task automatic step(input logic s, input logic sm, input logic [7:0] rl,
                        input logic [15:0] b, input logic st, input logic fl);
        @(negedge clk);
        start = s; is_sm = sm; reg_list = rl; base_addr = b;
        stall_in = st; flush = fl;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(s, sm, rl, b, st, fl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(uop_valid), 32'd0);
        check({tag, "_is_sm"}, 32'(uop_is_sm), 32'd0);
        check({tag, "_reg"}, 32'(uop_reg_add), 32'd0);
        check({tag, "_addr"}, 32'(uop_mem_addr), 32'd0);
        check({tag, "_last"}, 32'(uop_last), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_stall_up"}, 32'(stall_upstream), 32'd0);
    endtask

    initial begin
        // Power-on reset
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // LM R0,R2,R7 from 0x0100
        step(1'b1, 1'b0, 8'b1000_0101, 16'h0100, 1'b0, 1'b0);
        idle(4);

        // SM all registers, address wraps past 0xFFFF
        step(1'b1, 1'b1, 8'hFF, 16'hFFFE, 1'b0, 1'b0);
        idle(9);

        // Empty list: done only
        step(1'b1, 1'b0, 8'h00, 16'h1234, 1'b0, 1'b0);
        idle(2);

        // Stall the first micro-op for two cycles
        step(1'b1, 1'b0, 8'b0000_0110, 16'h2000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0);
        idle(4);

        // Flush on the second micro-op, with a coincident start
        step(1'b1, 1'b1, 8'h0F, 16'h3000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h03, 16'h4000, 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset mid-sequence, then a fresh instruction
        step(1'b1, 1'b0, 8'hFF, 16'h5000, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        exp_done = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b1, 8'h81, 16'h0010, 1'b0, 1'b0);
        idle(4);

        // Random traffic: starts (also while busy), stalls and flushes
        for (int i = 0; i < 800; i++) begin
            logic [7:0] rl;
            rl = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            step(1'($urandom_range(0, 2) == 0), 1'($urandom), rl, 16'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
        end
        idle(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, declared first: clk in 1 (rising-edge clock); reset_n in 1 (async active-low reset).
REQ-002 The block SHALL have these data ports:
- start in 1: decoded LM/SM present in register-read stage, valid this cycle.
- is_sm in 1: 1 = SM (opcode 4'b0111), 0 = LM (opcode 4'b0110); sampled with start.
- reg_list in 8: imm8 register mask; bit i selects Ri.
- base_addr in 16: RA contents; sampled with start.
- stall_in in 1: downstream stage cannot accept a micro-op this cycle.
- flush in 1: pipeline redirect (R7 write or branch); aborts the sequence.
- stall_upstream out 1: hold PC and the IF/ID and ID/RR registers.
- uop_valid out 1: a micro-op is presented.
- uop_is_sm out 1: the micro-op is a store (1) or a load (0).
- uop_reg_add out 3: register to write (LM) or read (SM); feeds wr_add downstream.
- uop_mem_addr out 16: memory address for this transfer.
- uop_last out 1: final micro-op of the instruction.
- done out 1: one-cycle pulse when the instruction completes.

Function
REQ-003 The FSM SHALL have two states: IDLE and RUN.
REQ-004 In IDLE with start=1 and reg_list!=0, the block SHALL latch mask=reg_list, addr=base_addr and op=is_sm, then enter RUN on the next edge.
REQ-005 In IDLE with start=1 and reg_list==0, the block SHALL stay in IDLE, emit no micro-op, and pulse done in the following cycle.
REQ-006 In RUN, uop_valid SHALL be 1, uop_reg_add SHALL be the index of the lowest set bit of mask, and uop_mem_addr SHALL equal addr.
- All three SHALL be combinational from registered state.
REQ-007 In RUN with stall_in=0, the block SHALL, on the next edge, clear that mask bit and set addr=addr+1.
REQ-008 In RUN with stall_in=1, mask, addr and all uop_* outputs SHALL hold unchanged.
REQ-009 uop_last SHALL be 1 exactly when mask has one bit set. An accepted last micro-op SHALL return the FSM to IDLE and pulse done in the next cycle.
REQ-010 Address arithmetic SHALL be 16-bit modulo: 16'hFFFF+1 = 16'h0000, with no error.
REQ-011 Latency: start in cycle N SHALL produce the first uop_valid in cycle N+1. A list of k bits with no stalls SHALL produce k consecutive micro-ops in cycles N+1..N+k and done in cycle N+k+1.
REQ-012 stall_upstream SHALL equal (state==RUN && !(uop_last && !stall_in)) || (start && reg_list!=0 && state==IDLE), combinationally.
REQ-013 flush SHALL have priority over all other inputs. On flush, the next edge SHALL force IDLE and mask=0, with no done pulse.
- A start coincident with flush SHALL be ignored.
REQ-014 start asserted in RUN SHALL be ignored; upstream is stalled, so this is an upstream error.
REQ-015 LM with bit 7 set SHALL issue R7 last, since R7 is the highest index. Redirect handling belongs downstream via flush.
REQ-016 uop_is_sm SHALL equal the latched op throughout RUN.

Reset
REQ-017 While reset_n=0, the block SHALL hold state=IDLE, mask=0, addr=0, op=0 and done=0. All outputs SHALL read 0, except uop_reg_add and uop_mem_addr, which SHALL read 0.
REQ-018 Reset deassertion mid-sequence SHALL resume from IDLE. An in-flight instruction is lost, and no done pulse SHALL be issued.

Structure
REQ-019 The shared package SHALL hold the opcode constants (LM=4'b0110, SM=4'b0111, LW=4'b0100, ADD/NDU class 4'b0000/4'b0010) and the FSM state encoding.
REQ-020 One sub-module, lsb_priority_enc8, SHALL implement the 8-to-3 lowest-set-bit encoder plus a one-hot "single bit" flag used for uop_last.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- LM reg_list=8'b1000_0101, base=16'h0100, no stalls -> micro-ops (R0,0100), (R2,0101), (R7,0102), last on the third; done the next cycle.
- SM reg_list=8'hFF, base=16'hFFFE -> eight micro-ops with addresses FFFE, FFFF, 0000 .. 0005 and uop_is_sm=1 throughout.
- reg_list=8'h00 -> no uop_valid, stall_upstream=0, done pulse in cycle N+1.
- LM reg_list=8'b0000_0110, stall_in high for 2 cycles on the first micro-op -> (R1,addr) held 3 cycles, then (R2,addr+1); stall_upstream high until the last micro-op is accepted.
- flush on the second micro-op of reg_list=8'h0F -> IDLE next edge, no further micro-ops, no done pulse, stall_upstream=0.
- reset_n low mid-sequence -> all outputs 0 immediately (async); after release a new start runs correctly.
